// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: N-digit seven-segment scan controller.
// A binary value is accepted over a valid/ready handshake and converted to
// BCD with shift-add-3, one bit per clock. The digits are then time-multiplexed
// at CLK_HZ/SCAN_HZ clocks per digit, with per-digit dots, leading-zero
// blanking and an overflow pattern.
// Handshake: a value transfers on a rising clk edge where in_valid && in_ready;
// in_ready is high only in IDLE, and offers made while it is low are dropped.
// Optional macro FND_DIM_EN adds a 4-bit brightness input that gates the digit
// enable inside each scan slot.
module fnd_scan_controller #(
   parameter int NUM_DIGITS = 4,
   parameter int DATA_WIDTH = 14,
   parameter int CLK_HZ     = 100_000_000,
   parameter int SCAN_HZ    = 1000,
   parameter bit ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic [NUM_DIGITS-1:0] dot_mask,
   input  logic                  blank_lz,
`ifdef FND_DIM_EN
   input  logic [3:0]            brightness,
`endif
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] fnd_digit,
   output logic [7:0]            fnd_data
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int BCD_W = 4 * NUM_DIGITS;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0]           LIMIT   = pow10(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] ONE     = 1;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? '1 : '0;
   localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

   // Active-low segment pattern {dp,g,f,e,d,c,b,a}, dot off.
   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0: return 8'hC0;
         4'd1: return 8'hF9;
         4'd2: return 8'hA4;
         4'd3: return 8'hB0;
         4'd4: return 8'h99;
         4'd5: return 8'h92;
         4'd6: return 8'h82;
         4'd7: return 8'hF8;
         4'd8: return 8'h80;
         4'd9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int d = 0; d < NUM_DIGITS; d++)
         if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

   state_t                state_q, state_nxt;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] value_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [BCD_W-1:0]      bcd_q;
   logic [BCD_W-1:0]      bcd_adj;
   logic [BCD_W-1:0]      disp_q;
   logic [PRE_W-1:0]      presc_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  tick;
   logic [3:0]            digit_val;
   logic                  blank;
   logic [7:0]            seg_l;
   logic [7:0]            seg_out;
   logic [NUM_DIGITS-1:0] onehot;
   logic [NUM_DIGITS-1:0] dig_out;

   // Conversion FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nxt;
   end

   // Next state and handshake ready.
   always_comb begin
      state_nxt = state_q;
      in_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = CONVERT;
         end
         CONVERT: if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bcd_adj = add3(bcd_q);

   // Conversion datapath: latch, shift-add-3 iterations, then publish.
   // Only the low NUM_DIGITS BCD digits are kept; larger values show the
   // overflow pattern, so the truncated upper digits are never displayed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         value_q  <= '0;
         shift_q  <= '0;
         bcd_q    <= '0;
         disp_q   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               value_q <= in_data;
               shift_q <= in_data;
               bcd_q   <= '0;
               cnt_q   <= '0;
            end
            CONVERT: begin
               bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[DATA_WIDTH-1]};
               shift_q <= shift_q << 1;
               cnt_q   <= cnt_q + CNT_W'(1);
            end
            LOAD: begin
               disp_q   <= bcd_q;
               overflow <= ({{(64-DATA_WIDTH){1'b0}}, value_q} >= LIMIT);
            end
            default: ;
         endcase
      end
   end

   assign tick = (presc_q == PRE_W'(DIV - 1));

   // Pattern for the digit about to be scanned out.
   always_comb begin
      digit_val = disp_q[{idx_q, 2'b00} +: 4];
      blank     = blank_lz && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
      if (overflow)   seg_l = 8'hBF;
      else if (blank) seg_l = 8'hFF;
      else            seg_l = seg_decode(digit_val);
      if (dot_mask[idx_q]) seg_l[7] = 1'b0;
      seg_out = ACTIVE_LOW ? seg_l : ~seg_l;
      onehot  = ONE << idx_q;
      dig_out = ACTIVE_LOW ? ~onehot : onehot;
   end

`ifdef FND_DIM_EN
   logic [PRE_W-1:0]      presc_nxt;
   logic [NUM_DIGITS-1:0] sel_q;
   logic [NUM_DIGITS-1:0] sel_nxt;
   logic                  dim_on;

   // Slot position of the coming cycle decides whether the digit is lit.
   always_comb begin
      presc_nxt = tick ? '0 : presc_q + PRE_W'(1);
      sel_nxt   = tick ? onehot : sel_q;
      dim_on    = ((int'(presc_nxt) * 16) / DIV) <= int'(brightness);
   end
`endif

   // Scan prescaler, digit index and registered pin outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         idx_q     <= '0;
         fnd_digit <= DIG_OFF;
         fnd_data  <= SEG_OFF;
`ifdef FND_DIM_EN
         sel_q     <= '0;
`endif
      end else begin
         presc_q <= tick ? '0 : presc_q + PRE_W'(1);
         if (tick) begin
            fnd_data <= seg_out;
            idx_q    <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end
`ifdef FND_DIM_EN
         if (tick) sel_q <= onehot;
         fnd_digit <= dim_on ? (ACTIVE_LOW ? ~sel_nxt : sel_nxt) : DIG_OFF;
`else
         if (tick) fnd_digit <= dig_out;
`endif
      end
   end

endmodule
